// File: rtl/ripple_pixel_shader_pkg.sv
// Shared definitions for the ripple pixel shader: ripple state encoding,
// ring level width and the row/col width used by the areaconfig stage.
// No ports.
package ripple_pixel_shader_pkg;

    localparam int LVL_W    = 8;
    localparam int ROWCOL_W = 7;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RING1 = 3'd1;
    localparam logic [2:0] ST_RING2 = 3'd2;
    localparam logic [2:0] ST_RING3 = 3'd3;
    localparam logic [2:0] ST_DECAY = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        RING1 = ST_RING1,
        RING2 = ST_RING2,
        RING3 = ST_RING3,
        DECAY = ST_DECAY
    } state_t;

endpackage

// File: rtl/ripple_color_scale.sv
// Scales one 8-bit colour channel by a ring level: (level * coef) >> 8,
// truncated, no rounding.
// Ports:
//   i_level   ring level selected for the pixel
//   i_coef    base colour channel
//   o_scaled  scaled channel value
module ripple_color_scale
    import ripple_pixel_shader_pkg::*;
(
    input  logic [LVL_W-1:0] i_level,
    input  logic [7:0]       i_coef,
    output logic [7:0]       o_scaled
);

    logic [15:0] w_prod;

    assign w_prod   = 16'(i_level) * 16'(i_coef);
    assign o_scaled = 8'(w_prod >> 8);

endmodule

// File: rtl/ripple_pixel_shader.sv
// Ripple pixel shader: turns per-pixel ring flags into animated RGB.
// A touch trigger plays centre -> inner ring -> outer ring ignition, then all
// rings halve in brightness each animation step until dark.
// Optional build macro RIPPLE_RETRIGGER_EN: a trigger while busy restarts the
// ripple on the next frame_start instead of queueing one replay.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   i_frame_start               pulse before the first pixel of a frame
//   i_trigger                   touch pulse
//   i_pix_valid, i_judge1..3    pixel strobe and centre/inner/outer flags
//   o_rgb_valid, o_rgb_r/g/b    pixel colour, 2 cycles after i_pix_valid
//   o_busy                      animation running
//
// state | meaning
// IDLE  | dark, waiting for a trigger
// RING1 | centre lit
// RING2 | inner ring ignited, centre fading
// RING3 | outer ring ignited, others fading
// DECAY | all rings fading until every level is zero
module ripple_pixel_shader
    import ripple_pixel_shader_pkg::*;
#(
    parameter int          FRAMES_PER_STEP = 4,
    parameter logic [23:0] COLOR           = 24'hFF8000,
    parameter logic [7:0]  LVL_MAX         = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_frame_start,
    input  logic       i_trigger,
    input  logic       i_pix_valid,
    input  logic       i_judge1,
    input  logic       i_judge2,
    input  logic       i_judge3,
    output logic       o_rgb_valid,
    output logic [7:0] o_rgb_r,
    output logic [7:0] o_rgb_g,
    output logic [7:0] o_rgb_b,
    output logic       o_busy
);

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    state_t           r_state;
    logic [LVL_W-1:0] r_lvl1, r_lvl2, r_lvl3;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_pend;
    logic             r_busy;

    logic             w_step;
    logic             w_req;
    logic             w_all_zero;

    assign w_step     = i_frame_start && (r_frame_cnt == CNT_LAST);
    // A trigger landing on the same cycle as frame_start counts for it.
    assign w_req      = r_pend || i_trigger;
    assign w_all_zero = ((r_lvl1 >> 1) == '0) && ((r_lvl2 >> 1) == '0) && ((r_lvl3 >> 1) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lvl1      <= '0;
            r_lvl2      <= '0;
            r_lvl3      <= '0;
            r_frame_cnt <= '0;
            r_pend      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_frame_cnt <= '0;
                    if (i_frame_start && w_req) begin
                        r_state <= RING1;
                        r_busy  <= 1'b1;
                        r_lvl1  <= LVL_MAX;
                        r_lvl2  <= '0;
                        r_lvl3  <= '0;
                        r_pend  <= 1'b0;
                    end else if (i_trigger) begin
                        r_pend <= 1'b1;
                    end
                end
                default: begin
                    if (i_trigger) begin
                        r_pend <= 1'b1;
                    end
`ifdef RIPPLE_RETRIGGER_EN
                    if (i_frame_start && w_req) begin
                        r_state     <= RING1;
                        r_lvl1      <= LVL_MAX;
                        r_lvl2      <= '0;
                        r_lvl3      <= '0;
                        r_frame_cnt <= '0;
                        r_pend      <= 1'b0;
                    end else
`endif
                    if (w_step) begin
                        r_frame_cnt <= '0;
                        case (r_state)
                            RING1: begin
                                r_state <= RING2;
                                r_lvl1  <= r_lvl1 >> 1;
                                r_lvl2  <= LVL_MAX;
                            end
                            RING2: begin
                                r_state <= RING3;
                                r_lvl1  <= r_lvl1 >> 1;
                                r_lvl2  <= r_lvl2 >> 1;
                                r_lvl3  <= LVL_MAX;
                            end
                            default: begin
                                r_lvl1 <= r_lvl1 >> 1;
                                r_lvl2 <= r_lvl2 >> 1;
                                r_lvl3 <= r_lvl3 >> 1;
                                if (w_all_zero) begin
                                    r_state <= IDLE;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_state <= DECAY;
                                end
                            end
                        endcase
                    end else if (i_frame_start) begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // S1: ring select, centre has priority over inner over outer.
    logic [LVL_W-1:0] w_sel;
    logic [LVL_W-1:0] r_sel;
    logic             r_vld1;

    always_comb begin
        w_sel = '0;
        if (i_pix_valid) begin
            if (i_judge1)      w_sel = r_lvl1;
            else if (i_judge2) w_sel = r_lvl2;
            else if (i_judge3) w_sel = r_lvl3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel  <= '0;
            r_vld1 <= 1'b0;
        end else begin
            r_sel  <= w_sel;
            r_vld1 <= i_pix_valid;
        end
    end

    // S2: colour scaling.
    logic [7:0] w_r, w_g, w_b;
    logic [7:0] r_rgb_r, r_rgb_g, r_rgb_b;
    logic       r_rgb_valid;

    ripple_color_scale u_scale_r (.i_level(r_sel), .i_coef(COLOR[23:16]), .o_scaled(w_r));
    ripple_color_scale u_scale_g (.i_level(r_sel), .i_coef(COLOR[15:8]),  .o_scaled(w_g));
    ripple_color_scale u_scale_b (.i_level(r_sel), .i_coef(COLOR[7:0]),   .o_scaled(w_b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb_valid <= 1'b0;
            r_rgb_r     <= '0;
            r_rgb_g     <= '0;
            r_rgb_b     <= '0;
        end else begin
            r_rgb_valid <= r_vld1;
            r_rgb_r     <= r_vld1 ? w_r : 8'd0;
            r_rgb_g     <= r_vld1 ? w_g : 8'd0;
            r_rgb_b     <= r_vld1 ? w_b : 8'd0;
        end
    end

    assign o_rgb_valid = r_rgb_valid;
    assign o_rgb_r     = r_rgb_r;
    assign o_rgb_g     = r_rgb_g;
    assign o_rgb_b     = r_rgb_b;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_ripple_pixel_shader.sv
// Directed bench for ripple_pixel_shader with FRAMES_PER_STEP=2,
// COLOR=24'hFF8000, LVL_MAX=255. Expected colours are hand computed:
// level 255 -> FE/7F/00, 127 -> 7E/3F/00, 63 -> 3E/1F/00, 31 -> 1E/0F/00,
// 15 -> 0E/07/00, 3 -> 02/01/00.
module tb_ripple_pixel_shader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start, trigger, pix_valid, judge1, judge2, judge3;
    logic       rgb_valid;
    logic [7:0] rgb_r, rgb_g, rgb_b;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ripple_pixel_shader #(
        .FRAMES_PER_STEP(2),
        .COLOR(24'hFF8000),
        .LVL_MAX(8'd255)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_frame_start(frame_start),
        .i_trigger(trigger),
        .i_pix_valid(pix_valid),
        .i_judge1(judge1),
        .i_judge2(judge2),
        .i_judge3(judge3),
        .o_rgb_valid(rgb_valid),
        .o_rgb_r(rgb_r),
        .o_rgb_g(rgb_g),
        .o_rgb_b(rgb_b),
        .o_busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [23:0] obs, input logic [23:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic check_pix(input logic j1, input logic j2, input logic j3,
                             input logic [23:0] exp, input string tag);
        pix_valid = 1'b1;
        judge1 = j1; judge2 = j2; judge3 = j3;
        tick();
        pix_valid = 1'b0;
        judge1 = 1'b0; judge2 = 1'b0; judge3 = 1'b0;
        tick();
        chk({23'd0, rgb_valid}, 24'd1, {tag, "_valid"});
        chk({rgb_r, rgb_g, rgb_b}, exp, {tag, "_rgb"});
    endtask

    initial begin
        logic [7:0] pv_pat;
        logic       prev_pv;

        rst_n = 1'b0;
        frame_start = 1'b0; trigger = 1'b0; pix_valid = 1'b0;
        judge1 = 1'b0; judge2 = 1'b0; judge3 = 1'b0;
        tick(); tick();
        chk({23'd0, busy}, 24'd0, "rst_busy");
        chk({23'd0, rgb_valid}, 24'd0, "rst_rgb_valid");
        chk({rgb_r, rgb_g, rgb_b}, 24'h000000, "rst_rgb");
        rst_n = 1'b1;
        tick();

        // 1: pipeline latency with no animation running
        pv_pat  = 8'b1011_0110;
        prev_pv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pix_valid = pv_pat[i];
            judge1    = 1'b1;
            tick();
            chk({23'd0, rgb_valid}, {23'd0, prev_pv}, "lat_valid");
            chk({rgb_r, rgb_g, rgb_b}, 24'h000000, "lat_rgb_dark");
            prev_pv = pv_pat[i];
        end
        pix_valid = 1'b0; judge1 = 1'b0;
        tick(); tick();
        chk({23'd0, busy}, 24'd0, "idle_busy");

        // 2: trigger then frame_start ignites the centre
        pulse_trigger();
        chk({23'd0, busy}, 24'd0, "pend_not_busy");
        frame();
        chk({23'd0, busy}, 24'd1, "ring1_busy");
        check_pix(1'b1, 1'b0, 1'b0, 24'hFE7F00, "ring1_centre");
        check_pix(1'b0, 1'b1, 1'b0, 24'h000000, "ring1_ring2");
        check_pix(1'b1, 1'b1, 1'b1, 24'hFE7F00, "ring1_prio");

        // 3: one step -> RING2
        frame();
        check_pix(1'b1, 1'b0, 1'b0, 24'hFE7F00, "ring1_cnt1_centre");
        frame();
        check_pix(1'b1, 1'b0, 1'b0, 24'h7E3F00, "ring2_centre");
        check_pix(1'b0, 1'b1, 1'b0, 24'hFE7F00, "ring2_ring2");
        check_pix(1'b0, 1'b0, 1'b1, 24'h000000, "ring2_ring3");
        check_pix(1'b0, 1'b1, 1'b1, 24'hFE7F00, "ring2_prio");

        // 4: run to completion, busy drops on step 10
        for (int s = 2; s <= 10; s++) begin
            frame();
            chk({23'd0, busy}, 24'd1, "run_mid_busy");
            frame();
            chk({23'd0, busy}, {23'd0, (s < 10)}, "run_step_busy");
            if (s == 2) begin
                check_pix(1'b1, 1'b0, 1'b0, 24'h3E1F00, "ring3_centre");
                check_pix(1'b0, 1'b0, 1'b1, 24'hFE7F00, "ring3_ring3");
            end
            if (s == 8) begin
                check_pix(1'b0, 1'b0, 1'b1, 24'h020100, "decay8_ring3");
                check_pix(1'b1, 1'b0, 1'b0, 24'h000000, "decay8_centre");
            end
        end
        check_pix(1'b0, 1'b0, 1'b1, 24'h000000, "done_dark");
        frame();
        chk({23'd0, busy}, 24'd0, "idle_frame_no_start");

        // 5: retrigger during DECAY
        pulse_trigger();
        frame();
        for (int k = 0; k < 6; k++) frame();
        check_pix(1'b1, 1'b0, 1'b0, 24'h1E0F00, "decay3_centre");
        pulse_trigger();
`ifdef RIPPLE_RETRIGGER_EN
        frame();
        chk({23'd0, busy}, 24'd1, "retrig_busy");
        check_pix(1'b1, 1'b0, 1'b0, 24'hFE7F00, "retrig_centre");
        check_pix(1'b0, 1'b1, 1'b0, 24'h000000, "retrig_ring2");
        check_pix(1'b0, 1'b0, 1'b1, 24'h000000, "retrig_ring3");
        frame();
        check_pix(1'b1, 1'b0, 1'b0, 24'hFE7F00, "retrig_cnt1_centre");
        frame();
        check_pix(1'b1, 1'b0, 1'b0, 24'h7E3F00, "retrig_step_centre");
        check_pix(1'b0, 1'b1, 1'b0, 24'hFE7F00, "retrig_step_ring2");
`else
        frame();
        chk({23'd0, busy}, 24'd1, "queued_busy");
        check_pix(1'b1, 1'b0, 1'b0, 24'h1E0F00, "queued_no_restart");
        frame();
        check_pix(1'b1, 1'b0, 1'b0, 24'h0E0700, "decay4_centre");
        for (int k = 0; k < 6; k++) begin
            frame();
            frame();
            chk({23'd0, busy}, {23'd0, (k < 5)}, "queued_run_busy");
        end
        frame();
        chk({23'd0, busy}, 24'd1, "queued_restart_busy");
        check_pix(1'b1, 1'b0, 1'b0, 24'hFE7F00, "queued_centre");
        check_pix(1'b0, 1'b1, 1'b0, 24'h000000, "queued_ring2");
`endif

        // 6: asynchronous reset mid-RING2 with a pending trigger
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_trigger();
        frame(); frame(); frame();
        pulse_trigger();
        pix_valid = 1'b1; judge2 = 1'b1;
        tick(); tick();
        chk({23'd0, rgb_valid}, 24'd1, "pre_rst_valid");
        chk({rgb_r, rgb_g, rgb_b}, 24'hFE7F00, "pre_rst_rgb");
        #2;
        rst_n = 1'b0;
        #1;
        chk({23'd0, rgb_valid}, 24'd0, "async_rst_valid");
        chk({rgb_r, rgb_g, rgb_b}, 24'h000000, "async_rst_rgb");
        chk({23'd0, busy}, 24'd0, "async_rst_busy");
        pix_valid = 1'b0; judge2 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        frame();
        chk({23'd0, busy}, 24'd0, "pend_lost");
        frame();
        chk({23'd0, busy}, 24'd0, "pend_lost2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
